// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back, and decodes every datapath enable and select.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADDR = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t state;

  // NOTE: state is sequential, so it is assigned with <= only; blocking
  // assignments here would race with every reader of state on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (MemReady) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_LW, OP_SW: state <= MEMADDR;
            OP_RTYPE:     state <= EXEC;
            OP_BEQ:       state <= BRANCH;
            OP_J:         state <= JUMP;
            OP_ADDI:      state <= ADDIEX;
            default:      state <= FETCH;
          endcase
        end
        MEMADDR: state <= (Op == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (MemReady) state <= MEMWB;
        MEMWB:   state <= FETCH;
        MEMWR:   if (MemReady) state <= FETCH;
        EXEC:    state <= RWB;
        RWB:     state <= FETCH;
        BRANCH:  state <= FETCH;
        JUMP:    state <= FETCH;
        ADDIEX:  state <= ADDIWB;
        ADDIWB:  state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end

  assign State = state;

  // Outputs are decoded from the state; only the fetch write pulse (MemReady)
  // and IllegalOp (Op) look at inputs. Strobes are gated by reset so nothing
  // writes while reset is held, even though State already reads FETCH.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves one unassigned, which would infer a latch.
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    IllegalOp   = 1'b0;
    case (state)
      FETCH: begin
        MemRead = ~reset;
        ALUSrcB = 2'b01;
        IRWrite = MemReady & ~reset;
        PCWrite = MemReady & ~reset;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: IllegalOp = 1'b0;
          default:                                       IllegalOp = ~reset;
        endcase
      end
      MEMADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = ~reset;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = ~reset;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = ~reset;
        IorD     = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      RWB: begin
        RegWrite = ~reset;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = ~reset;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = ~reset;
        PCSource = 2'b10;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: begin
        RegWrite = ~reset;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: an instruction-level model expands
// each opcode into its expected cycle sequence, checked state by state.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;

  int compared = 0;
  int mismatched = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, srcA;
    logic [1:0] srcB, aluop, pcsrc;
    logic       ill;
  } ctrl_t;

  typedef struct {
    int         st;
    logic       mrdy;
    logic [5:0] op;
  } cyc_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  cyc_t seq[$];

  function automatic bit isLegal(input logic [5:0] op);
    return op inside {LW, SW, RT, BEQ, JMP, ADDI};
  endfunction

  function automatic logic [5:0] rndOp();
    return 6'($urandom);
  endfunction

  // Control word the specification lists for each state.
  function automatic ctrl_t expCtrl(input int st, input logic mrdy, input logic [5:0] op);
    ctrl_t c = '0;
    case (st)
      0:  begin c.mr = 1; c.srcB = 2'b01; c.irw = mrdy; c.pcw = mrdy; end
      1:  begin c.srcB = 2'b11; c.ill = !isLegal(op); end
      2:  begin c.srcA = 1; c.srcB = 2'b10; end
      3:  begin c.mr = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mw = 1; c.iord = 1; end
      6:  begin c.srcA = 1; c.aluop = 2'b10; end
      7:  begin c.rw = 1; c.rd = 1; end
      8:  begin c.srcA = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin c.srcA = 1; c.srcB = 2'b10; end
      11: begin c.rw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic ctrl_t resetCtrl();
    ctrl_t c = '0;
    c.srcB = 2'b01;
    return c;
  endfunction

  function automatic ctrl_t observed();
    return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
  endfunction

  function automatic cyc_t mk(input int st, input logic mrdy, input logic [5:0] op);
    cyc_t c;
    c.st = st; c.mrdy = mrdy; c.op = op;
    return c;
  endfunction

  // Instruction-level model: one entry per expected cycle. Op carries the real
  // opcode only where it is sampled; elsewhere it and MemReady are noise.
  task automatic buildInstr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) seq.push_back(mk(0, 1'b0, rndOp()));
    seq.push_back(mk(0, 1'b1, rndOp()));
    seq.push_back(mk(1, 1'($urandom), op));
    if (op == LW || op == SW) begin
      seq.push_back(mk(2, 1'($urandom), op));
      for (int i = 0; i < mw; i++) seq.push_back(mk(op == LW ? 3 : 5, 1'b0, rndOp()));
      seq.push_back(mk(op == LW ? 3 : 5, 1'b1, rndOp()));
      if (op == LW) seq.push_back(mk(4, 1'($urandom), rndOp()));
    end else if (op == RT) begin
      seq.push_back(mk(6, 1'($urandom), rndOp()));
      seq.push_back(mk(7, 1'($urandom), rndOp()));
    end else if (op == BEQ) begin
      seq.push_back(mk(8, 1'($urandom), rndOp()));
    end else if (op == JMP) begin
      seq.push_back(mk(9, 1'($urandom), rndOp()));
    end else if (op == ADDI) begin
      seq.push_back(mk(10, 1'($urandom), rndOp()));
      seq.push_back(mk(11, 1'($urandom), rndOp()));
    end
  endtask

  // Entered 1 ns after a rising edge; drives, checks at the falling edge,
  // and returns 1 ns after the next rising edge.
  task automatic doCycle(input cyc_t c, input string tag);
    ctrl_t exp, obs;
    MemReady = c.mrdy;
    Op       = c.op;
    #4;
    exp = expCtrl(c.st, c.mrdy, c.op);
    obs = observed();
    compared++;
    assert (State === 4'(c.st)) else begin
      mismatched++;
      $error("FAIL %s state: got %0d want %0d", tag, State, c.st);
    end
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s ctrl (state %0d): got %h want %h", tag, c.st, obs, exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runSeq(input string tag);
    while (seq.size() > 0) doCycle(seq.pop_front(), tag);
  endtask

  task automatic checkReset(input string tag);
    compared++;
    assert (State === 4'd0) else begin
      mismatched++;
      $error("FAIL %s state: got %0d want 0", tag, State);
    end
    compared++;
    assert (observed() === resetCtrl()) else begin
      mismatched++;
      $error("FAIL %s ctrl: got %h want %h", tag, observed(), resetCtrl());
    end
  endtask

  initial begin
    logic [5:0] op;
    reset = 1'b1;
    MemReady = 1'b1;
    Op = 6'b0;
    #3;
    checkReset("reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed: lw with three memory waits, then every other class.
    buildInstr(LW, 0, 3);     runSeq("lw_wait");
    buildInstr(RT, 0, 0);     runSeq("rtype");
    buildInstr(BEQ, 0, 0);    runSeq("beq");
    buildInstr(JMP, 0, 0);    runSeq("jump");
    buildInstr(SW, 1, 2);     runSeq("sw_wait");
    buildInstr(ADDI, 0, 0);   runSeq("addi");
    buildInstr(6'b111111, 0, 0); runSeq("illegal");

    // Reset mid-MEMRD: five cycles in, MemReady high but reset wins.
    buildInstr(LW, 0, 4);
    for (int i = 0; i < 5; i++) doCycle(seq.pop_front(), "lw_abort");
    seq.delete();
    MemReady = 1'b1;
    Op = rndOp();
    #2;
    reset = 1'b1;
    #1;
    checkReset("reset_async");
    @(posedge clk);
    #1;
    checkReset("reset_clocked");
    reset = 1'b0;

    // Randomized instruction stream with random fetch and memory waits.
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: op = LW;
        1: op = SW;
        2: op = RT;
        3: op = BEQ;
        4: op = JMP;
        5: op = ADDI;
        default: begin
          op = rndOp();
          while (isLegal(op)) op = rndOp();
        end
      endcase
      buildInstr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      runSeq($sformatf("rand%0d_op%02h", n, op));
    end
    doCycle(mk(0, 1'b0, rndOp()), "final_fetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and write-back, driving every datapath enable and mux select. Its `ALUOp` output feeds `ALU_Control` directly, and `ALU_Control` combines it with the funct field. A `MemReady` handshake lets memory accesses stretch over several cycles.

## Interface
Parameters: none. State encoding is fixed (below).

- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `Op` in 6: opcode, `IR[31:26]`. Stable from the cycle after an IR write.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond` out 1: unconditional and branch-conditional PC write enables.
- `IorD` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite` out 1: memory strobes.
- `IRWrite` out 1: instruction register load.
- `MemtoReg` out 1: register write data select. 1 = MDR, 0 = ALUOut.
- `RegDst` out 1: destination register select. 1 = rd, 0 = rt.
- `RegWrite` out 1: register file write enable.
- `ALUSrcA` out 1: ALU A input select. 0 = PC, 1 = A.
- `ALUSrcB` out 2: ALU B input select. 00 = B, 01 = 4, 10 = signext imm, 11 = signext imm<<2.
- `ALUOp` out 2: 00 = add, 01 = subtract, 10 = decode funct. 11 is never driven.
- `PCSource` out 2: PC source select. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `IllegalOp` out 1: unsupported opcode detected in DECODE.
- `State` out 4: current state, for debug.

## Operation
State register is 4 bits; all outputs are decoded from the state (Moore), except for the qualifications stated below. Any output not listed for a state is 0.

- 0 FETCH: MemRead=1, ALUSrcB=01, ALUOp=00.
  - IRWrite = PCWrite = MemReady.
  - MemReady=1 → DECODE; otherwise stay in FETCH.
- 1 DECODE: ALUSrcB=11, ALUOp=00 (computes the branch target). Next state by `Op`:
  - 100011 (lw) or 101011 (sw) → MEMADDR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX
  - other → FETCH, with IllegalOp=1 for this cycle only.
- 2 MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
- 3 MEMRD: MemRead=1, IorD=1. Stays until MemReady=1, then → MEMWB.
- 4 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. → FETCH.
- 5 MEMWR: MemWrite=1, IorD=1. Stays until MemReady=1, then → FETCH.
- 6 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. → RWB.
- 7 RWB: RegWrite=1, RegDst=1, MemtoReg=0. → FETCH.
- 8 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. → FETCH.
- 9 JUMP: PCWrite=1, PCSource=10. → FETCH.
- 10 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. → ADDIWB.
- 11 ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. → FETCH.
- Codes 12–15 are unreachable. If entered, all outputs are 0 and the next state is FETCH.
- `Op` is sampled only in DECODE and MEMADDR. Changes to `Op` in any other state have no effect.

## Timing
- Reset:
  - Asserting `reset` forces State=FETCH immediately, without waiting for a clock edge.
  - While `reset` is high, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite and IllegalOp are forced to 0.
  - All other outputs show their FETCH values: ALUSrcB=01, all else 0.
- Reset mid-instruction aborts the instruction. No register or memory write occurs after reset asserts.
- The first FETCH cycle after reset releases behaves normally.
- Instruction latency in cycles, with MemReady held at 1 and counting from FETCH entry to return to FETCH:
  - lw 5
  - R-type 4
  - sw 4
  - addi 4
  - beq 3
  - j 3
  - illegal opcode 2
- Each cycle with MemReady=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- MemRead and MemWrite remain asserted, at their listed values, throughout a wait.
- IRWrite and PCWrite pulse only in the FETCH cycle where MemReady=1.
- MemReady is ignored in all states other than FETCH, MEMRD and MEMWR.

## Test plan
- Reset and fetch: assert reset mid-MEMRD → State=0 with no clock edge, MemRead=0. Release reset with MemReady=1 → IRWrite=PCWrite=1 for one cycle, then State=1.
- lw with waits: Op=100011, MemReady held at 0 for 3 cycles in MEMRD → state sequence 0,1,2,3,3,3,3,4,0. RegWrite=MemtoReg=1 only in state 4.
- R-type: Op=000000 → ALUOp=10 in state 6, then RegWrite=1 and RegDst=1 in state 7. Total 4 cycles.
- beq and j: Op=000100 → state 8 with ALUOp=01, PCWriteCond=1, PCSource=01. Op=000010 → state 9 with PCWrite=1, PCSource=10. Each takes 3 cycles.
- sw and addi: sw → states 0,1,2,5,0, with MemWrite=1 and IorD=1 only in state 5. addi (001000) → states 0,1,10,11,0, with ALUSrcB=10 in state 10.
- Illegal opcode: Op=111111 → IllegalOp=1 for exactly one cycle in DECODE, then State=0. No write enable is asserted during the instruction apart from the fetch PCWrite/IRWrite pulse.
